pwla_act_pipe: RTL

- Parametrised successor to the single-output PLAN sigmoid: a 3-stage pipelined piecewise-linear activation unit with valid/ready handshake and signed input.
- Negative-input symmetry (1 - f(|x|)) is handled internally, so testbenches no longer fold the sign.
- A per-sample mode selects sigmoid or tanh; tanh is computed as 2*sig(2x) - 1.
- Sits between the MAC accumulator and the activation write-back buffer.

---
 rtl/pwla_pkg.sv | 46 ++++
 rtl/pwla_segment_eval.sv | 38 +++
 rtl/pwla_act_pipe.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pwla_pkg.sv
// Shared types and FRAC_W-derived constants for the piecewise-linear activation unit.
// All constants are exact shift-add values of the PLAN sigmoid approximation.
package pwla_pkg;

   typedef enum logic {
      MODE_SIGMOID = 1'b0,
      MODE_TANH    = 1'b1
   } mode_e;

   typedef logic [1:0] seg_idx_t;

   localparam seg_idx_t SEG_LIN0 = 2'd0;
   localparam seg_idx_t SEG_LIN1 = 2'd1;
   localparam seg_idx_t SEG_LIN2 = 2'd2;
   localparam seg_idx_t SEG_SAT  = 2'd3;

   function automatic int pwla_one(input int frac_w);
      return 1 << frac_w;
   endfunction

   function automatic int pwla_half(input int frac_w);
      return 1 << (frac_w - 1);
   endfunction

   // 0.625 and 0.84375 are 5/8 and 27/32 of ONE.
   function automatic int pwla_off_mid(input int frac_w);
      return (5 << frac_w) >> 3;
   endfunction

   function automatic int pwla_off_hi(input int frac_w);
      return (27 << frac_w) >> 5;
   endfunction

   function automatic int pwla_thr_lo(input int frac_w);
      return 1 << frac_w;
   endfunction

   function automatic int pwla_thr_mid(input int frac_w);
      return (19 << frac_w) >> 3;
   endfunction

   function automatic int pwla_thr_hi(input int frac_w);
      return 5 << frac_w;
   endfunction

endpackage

// File: rtl/pwla_segment_eval.sv
// Combinational PLAN sigmoid on a non-negative magnitude: picks the segment and
// evaluates its shift-add line. Thresholds are inclusive at the lower edge.
module pwla_segment_eval
   import pwla_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 10
) (
   input  logic [DATA_W-2:0] mag,
   output seg_idx_t          seg,
   output logic [DATA_W-2:0] y
);

   localparam int MAG_W = DATA_W - 1;
   localparam logic [MAG_W-1:0] ONE     = MAG_W'(pwla_one(FRAC_W));
   localparam logic [MAG_W-1:0] HALF    = MAG_W'(pwla_half(FRAC_W));
   localparam logic [MAG_W-1:0] OFF_MID = MAG_W'(pwla_off_mid(FRAC_W));
   localparam logic [MAG_W-1:0] OFF_HI  = MAG_W'(pwla_off_hi(FRAC_W));
   localparam logic [MAG_W-1:0] THR_LO  = MAG_W'(pwla_thr_lo(FRAC_W));
   localparam logic [MAG_W-1:0] THR_MID = MAG_W'(pwla_thr_mid(FRAC_W));
   localparam logic [MAG_W-1:0] THR_HI  = MAG_W'(pwla_thr_hi(FRAC_W));

   always_comb begin
      seg = SEG_LIN0;
      y   = (mag >> 2) + HALF;
      if (mag >= THR_HI) begin
         seg = SEG_SAT;
         y   = ONE;
      end else if (mag >= THR_MID) begin
         seg = SEG_LIN2;
         y   = (mag >> 5) + OFF_HI;
      end else if (mag >= THR_LO) begin
         seg = SEG_LIN1;
         y   = (mag >> 3) + OFF_MID;
      end
   end

endmodule

// File: rtl/pwla_act_pipe.sv
// 3-stage pipelined PLAN sigmoid/tanh with valid/ready handshake and signed input.
// Each stage loads when empty or when the stage after it loads; in_ready chains back from out_ready.
module pwla_act_pipe
   import pwla_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 10,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   input  logic              in_mode,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_y,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int MAG_W = DATA_W - 1;
   localparam logic [MAG_W-1:0]        MAG_MAX = '1;
   localparam logic [MAG_W-1:0]        ONE_M   = MAG_W'(pwla_one(FRAC_W));
   localparam logic signed [DATA_W-1:0] ONE_S  = DATA_W'(pwla_one(FRAC_W));

   typedef struct packed {
      logic             vld;
      logic             sign;
      mode_e            mode;
      logic [TAG_W-1:0] tag;
      logic [MAG_W-1:0] a;
   } s1_t;

   typedef struct packed {
      logic             vld;
      logic             sign;
      mode_e            mode;
      logic [TAG_W-1:0] tag;
      logic [MAG_W-1:0] y;
   } s2_t;

   typedef struct packed {
      logic              vld;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] y;
   } s3_t;

   s1_t s1_d, s1_q;
   s2_t s2_d, s2_q;
   s3_t s3_d, s3_q;

   logic                     ld1, ld2, ld3;
   logic [DATA_W-1:0]        neg_x;
   logic [MAG_W-1:0]         abs_x;
   seg_idx_t                 seg;
   logic [MAG_W-1:0]         seg_y;
   logic signed [DATA_W-1:0] res;

   assign ld3       = !s3_q.vld || out_ready;
   assign ld2       = !s2_q.vld || ld3;
   assign ld1       = !s1_q.vld || ld2;
   assign in_ready  = ld1;
   assign out_valid = s3_q.vld;
   assign out_y     = s3_q.y;
   assign out_tag   = s3_q.tag;

   // The most negative input negates to itself, so its top bit flags saturation.
   always_comb begin
      neg_x = -in_x;
      if (!in_x[DATA_W-1])
         abs_x = in_x[MAG_W-1:0];
      else if (neg_x[DATA_W-1])
         abs_x = MAG_MAX;
      else
         abs_x = neg_x[MAG_W-1:0];

      s1_d = s1_q;
      if (ld1) begin
         s1_d.vld = in_valid;
         if (in_valid) begin
            s1_d.sign = in_x[DATA_W-1];
            s1_d.mode = mode_e'(in_mode);
            s1_d.tag  = in_tag;
            s1_d.a    = abs_x;
            if (mode_e'(in_mode) == MODE_TANH)
               s1_d.a = abs_x[MAG_W-1] ? MAG_MAX : (abs_x << 1);
         end
      end
   end

   pwla_segment_eval #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_seg (
      .mag (s1_q.a),
      .seg (seg),
      .y   (seg_y)
   );

   always_comb begin
      s2_d = s2_q;
      if (ld2) begin
         s2_d.vld = s1_q.vld;
         if (s1_q.vld) begin
            s2_d.sign = s1_q.sign;
            s2_d.mode = s1_q.mode;
            s2_d.tag  = s1_q.tag;
            s2_d.y    = (seg == SEG_SAT) ? ONE_M : seg_y;
         end
      end
   end

   // Result spans [-ONE, 2*ONE] before the final register, well inside DATA_W.
   always_comb begin
      res = $signed({1'b0, s2_q.y});
      if (s2_q.sign)
         res = ONE_S - res;
      if (s2_q.mode == MODE_TANH)
         res = (res <<< 1) - ONE_S;

      s3_d = s3_q;
      if (ld3) begin
         s3_d.vld = s2_q.vld;
         if (s2_q.vld) begin
            s3_d.tag = s2_q.tag;
            s3_d.y   = res;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

endmodule
